// File: rtl/hamming_sec_reader.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_sec_reader
//  Purpose  : Read-side controller for a DEPTH x 12-bit Hamming(12,8) SEC
//             codeword store. It fetches a codeword on request, computes the
//             syndrome and corrects single-bit errors. The 8-bit data and its
//             error status are returned over a valid/ready handshake.
//             Corrected codewords are written back to the store. On command,
//             it also runs a background scrub sweep over every address.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n               clock, asynchronous active-low reset
//    req_valid/req_ready      read request handshake, req_addr captured
//    rsp_valid/rsp_ready      response handshake
//    rsp_data/corr/uncorr     decoded data and status
//    scrub_start              start-sweep pulse (accepted in IDLE only)
//    scrub_busy/scrub_done    sweep active / one-cycle completion pulse
//    corr_cnt/uncorr_cnt      saturating event counters
//    mem_wr_en/addr/wdata     store write-back and address
//    mem_rdata                store read data (combinational on mem_addr)
// ============================================================================
module hamming_sec_reader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_corr,
    output logic             rsp_uncorr,
    input  logic             scrub_start,
    output logic             scrub_busy,
    output logic             scrub_done,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    output logic             mem_wr_en,
    output logic [AW-1:0]    mem_addr,
    output logic [11:0]      mem_wdata,
    input  logic [11:0]      mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_DEC  = 3'd2,
        S_WB   = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state_q;
    logic [AW-1:0]    addr_q;        // request address or sweep pointer
    logic [11:0]      cw_q;          // codeword fetched in RD
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;
    logic             rsp_corr_q;
    logic             rsp_uncorr_q;
    logic             scrub_busy_q;
    logic             scrub_done_q;
    logic [CNT_W-1:0] corr_cnt_q;
    logic [CNT_W-1:0] uncorr_cnt_q;
    logic             mem_wr_en_q;
    logic [AW-1:0]    mem_addr_q;
    logic [11:0]      mem_wdata_q;

    // Decode of the fetched codeword
    logic [3:0]  syn_d;
    logic [11:0] fixed_d;
    logic [7:0]  data_d;
    logic        corr_d;
    logic        uncorr_d;

    // Codeword bit i-1 holds Hamming position i; syndrome bit k covers
    // every position whose index has bit k set.
    always_comb begin
        syn_d[0] = cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6] ^ cw_q[8]  ^ cw_q[10];
        syn_d[1] = cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6] ^ cw_q[9]  ^ cw_q[10];
        syn_d[2] = cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6] ^ cw_q[11];
        syn_d[3] = cw_q[7] ^ cw_q[8] ^ cw_q[9] ^ cw_q[10] ^ cw_q[11];
    end

    assign corr_d   = (syn_d != 4'd0) && (syn_d <= 4'd12);
    assign uncorr_d = (syn_d >= 4'd13);

    // Syndromes 13..15 point past the word, so nothing is flipped and the
    // raw data positions pass through unchanged.
    always_comb begin
        fixed_d = cw_q;
        for (int i = 0; i < 12; i++) begin
            if (syn_d == 4'(i + 1)) begin
                fixed_d[i] = ~cw_q[i];
            end
        end
    end

    // Data d0..d7 live at positions 3,5,6,7,9,10,11,12
    assign data_d = {fixed_d[11], fixed_d[10], fixed_d[9], fixed_d[8],
                     fixed_d[6],  fixed_d[5],  fixed_d[4], fixed_d[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cw_q         <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_corr_q   <= 1'b0;
            rsp_uncorr_q <= 1'b0;
            scrub_busy_q <= 1'b0;
            scrub_done_q <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            scrub_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    mem_wr_en_q <= 1'b0;
                    mem_addr_q  <= '0;
                    // req_ready_q is low for the first cycle after reset;
                    // nothing is accepted until it has been raised.
                    if (req_ready_q && req_valid) begin
                        addr_q      <= req_addr;
                        mem_addr_q  <= req_addr;
                        req_ready_q <= 1'b0;
                        state_q     <= S_RD;
                    end else if (req_ready_q && scrub_start) begin
                        addr_q       <= '0;
                        mem_addr_q   <= '0;
                        scrub_busy_q <= 1'b1;
                        req_ready_q  <= 1'b0;
                        state_q      <= S_RD;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end

                S_RD: begin
                    cw_q    <= mem_rdata;
                    state_q <= S_DEC;
                end

                S_DEC: begin
                    // Sweep results only feed the counters and write-back
                    if (!scrub_busy_q) begin
                        rsp_data_q   <= data_d;
                        rsp_corr_q   <= corr_d;
                        rsp_uncorr_q <= uncorr_d;
                    end
                    if (corr_d && (corr_cnt_q != {CNT_W{1'b1}})) begin
                        corr_cnt_q <= corr_cnt_q + 1'b1;
                    end
                    if (uncorr_d && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
                        uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
                    end

                    if (corr_d) begin
                        mem_wr_en_q <= 1'b1;
                        mem_wdata_q <= fixed_d;
                        state_q     <= S_WB;
                    end else if (!scrub_busy_q) begin
                        mem_addr_q <= '0;
                        state_q    <= S_RSP;
                    end else if (addr_q == LAST_ADDR) begin
                        scrub_done_q <= 1'b1;
                        scrub_busy_q <= 1'b0;
                        addr_q       <= '0;
                        mem_addr_q   <= '0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        addr_q     <= addr_q + 1'b1;
                        mem_addr_q <= addr_q + 1'b1;
                        state_q    <= S_RD;
                    end
                end

                S_WB: begin
                    mem_wr_en_q <= 1'b0;
                    if (!scrub_busy_q) begin
                        mem_addr_q <= '0;
                        state_q    <= S_RSP;
                    end else if (addr_q == LAST_ADDR) begin
                        scrub_done_q <= 1'b1;
                        scrub_busy_q <= 1'b0;
                        addr_q       <= '0;
                        mem_addr_q   <= '0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        addr_q     <= addr_q + 1'b1;
                        mem_addr_q <= addr_q + 1'b1;
                        state_q    <= S_RD;
                    end
                end

                S_RSP: begin
                    // rsp_valid is raised on the first RSP cycle and held
                    // until the consumer samples it with rsp_ready high.
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_corr   = rsp_corr_q;
    assign rsp_uncorr = rsp_uncorr_q;
    assign scrub_busy = scrub_busy_q;
    assign scrub_done = scrub_done_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_sec_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hamming_sec_reader
//  Purpose  : Directed self-checking bench for hamming_sec_reader, with a
//             behavioural 16 x 12-bit store model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hamming_sec_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [3:0] req_addr;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_corr, rsp_uncorr;
    logic       scrub_start, scrub_busy, scrub_done;
    logic [7:0] corr_cnt, uncorr_cnt;
    logic       mem_wr_en;
    logic [3:0] mem_addr;
    logic [11:0] mem_wdata, mem_rdata;

    // Store model plus a bench-side preload port
    logic [11:0] store [16];
    logic        tb_we;
    logic [3:0]  tb_wa;
    logic [11:0] tb_wd;
    int          wr_cnt = 0;
    logic [15:0] wr_log [1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = store[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            store[mem_addr] <= mem_wdata;
            if (wr_cnt < 1024) wr_log[wr_cnt] <= {mem_addr, mem_wdata};
            wr_cnt <= wr_cnt + 1;
        end else if (tb_we) begin
            store[tb_wa] <= tb_wd;
        end
    end

    hamming_sec_reader #(.DEPTH(16), .AW(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_corr   (rsp_corr),
        .rsp_uncorr (rsp_uncorr),
        .scrub_start(scrub_start),
        .scrub_busy (scrub_busy),
        .scrub_done (scrub_done),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [3:0] a, input logic [11:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    // One read transaction: accept, measure latency to rsp_valid, check the
    // response and any write-back, then complete the handshake.
    task automatic do_read(input string tag, input logic [3:0] a,
                           input logic [7:0] ed, input logic ec, input logic eu,
                           input int elat, input int ewr, input logic [11:0] ewd);
        int n;
        int base;
        wait_ready(tag);
        req_valid = 1'b1; req_addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 4'd0;
        base = wr_cnt;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, n, elat);
        check({tag, " data"}, {24'd0, rsp_data}, {24'd0, ed});
        check({tag, " corr"}, {31'd0, rsp_corr}, {31'd0, ec});
        check({tag, " uncorr"}, {31'd0, rsp_uncorr}, {31'd0, eu});
        check({tag, " wb count"}, wr_cnt - base, ewr);
        if (ewr > 0) begin
            check({tag, " wb word"}, {16'd0, wr_log[base]}, {16'd0, a, ewd});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int base;
        logic rr_seen, rv_seen, stable;
        logic [7:0] held;

        rst_n = 1'b1; req_valid = 1'b0; req_addr = 4'd0; rsp_ready = 1'b0;
        scrub_start = 1'b0; tb_we = 1'b0; tb_wa = 4'd0; tb_wd = 12'd0;
        #2 rst_n = 1'b0;

        // Preload while in reset: all clean 0xA27 (data 0xA5)
        for (int i = 0; i < 16; i++) put(4'(i), 12'hA27);
        put(4'd5,  12'hA07);   // position 6 flipped
        put(4'd7,  12'h226);   // positions 1 and 12 flipped, syndrome 13
        put(4'd11, 12'h777);   // 0xF77 with position 12 flipped
        put(4'd0,  12'hF76);   // 0xF77 with position 1 flipped

        // Reset state
        check("reset req_ready", {31'd0, req_ready}, 32'd0);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("reset counters", {16'd0, corr_cnt, uncorr_cnt}, 32'd0);
        check("reset scrub_busy", {31'd0, scrub_busy}, 32'd0);

        @(posedge clk); #1; rst_n = 1'b1;

        do_read("clean",   4'd3,  8'hA5, 1'b0, 1'b0, 3, 0, 12'h000);
        do_read("single",  4'd5,  8'hA5, 1'b1, 1'b0, 4, 1, 12'hA27);
        check("single corr_cnt", {24'd0, corr_cnt}, 32'd1);
        check("single store fixed", {20'd0, store[5]}, {20'd0, 12'hA27});
        do_read("uncorr",  4'd7,  8'h25, 1'b0, 1'b1, 3, 0, 12'h000);
        check("uncorr cnt", {16'd0, corr_cnt, uncorr_cnt}, {16'd0, 8'd1, 8'd1});
        check("uncorr store kept", {20'd0, store[7]}, {20'd0, 12'h226});
        do_read("pos12",   4'd11, 8'hFF, 1'b1, 1'b0, 4, 1, 12'hF77);
        do_read("pos1",    4'd0,  8'hFF, 1'b1, 1'b0, 4, 1, 12'hF77);
        check("pos1 corr_cnt", {24'd0, corr_cnt}, 32'd3);

        // Backpressure: hold rsp_ready low for 10 cycles
        wait_ready("bp");
        req_valid = 1'b1; req_addr = 4'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("bp latency", n, 3);
        held = rsp_data;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data !== held || req_ready) stable = 1'b0;
        end
        check("bp stable", {31'd0, stable}, 32'd1);
        check("bp data", {24'd0, rsp_data}, {24'd0, 8'hA5});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp complete", {31'd0, rsp_valid}, 32'd0);

        // Sweep with single errors at 2 (position 6) and 9 (position 4)
        for (int i = 0; i < 16; i++) put(4'(i), 12'hA27);
        put(4'd2, 12'hA07);
        put(4'd9, 12'hA2F);
        wait_ready("sweep");
        base = wr_cnt;
        scrub_start = 1'b1;
        @(posedge clk); #1;
        check("sweep busy", {31'd0, scrub_busy}, 32'd1);
        n = 0; rr_seen = 1'b0; rv_seen = 1'b0;
        while (!scrub_done && n < 100) begin
            if (n == 5) begin req_valid = 1'b1; req_addr = 4'd3; end
            scrub_start = (n == 10);
            @(posedge clk); #1; n++;
            if (req_ready && !scrub_done) rr_seen = 1'b1;
            if (rsp_valid) rv_seen = 1'b1;
        end
        req_valid = 1'b0; scrub_start = 1'b0;
        check("sweep done cycle", n, 34);
        check("sweep req_ready low", {31'd0, rr_seen}, 32'd0);
        check("sweep no rsp", {31'd0, rv_seen}, 32'd0);
        check("sweep wb count", wr_cnt - base, 2);
        check("sweep wb0", {16'd0, wr_log[base]}, {16'd0, 4'd2, 12'hA27});
        check("sweep wb1", {16'd0, wr_log[base + 1]}, {16'd0, 4'd9, 12'hA27});
        check("sweep corr_cnt", {24'd0, corr_cnt}, 32'd5);
        @(posedge clk); #1;
        check("sweep done pulse", {30'd0, scrub_done, scrub_busy}, 32'd0);

        // Saturation: 17 sweeps of 16 corrected words exceed 255
        for (int s = 0; s < 17; s++) begin
            for (int i = 0; i < 16; i++) put(4'(i), 12'hA07);
            wait_ready("sat");
            scrub_start = 1'b1;
            @(posedge clk); #1;
            scrub_start = 1'b0;
            n = 0;
            while (!scrub_done && n < 100) begin
                @(posedge clk); #1; n++;
            end
            if (s == 0) check("sat sweep cycles", n, 48);
        end
        check("sat corr_cnt", {24'd0, corr_cnt}, 32'd255);
        check("sat uncorr_cnt", {24'd0, uncorr_cnt}, 32'd1);

        // Reset during write-back
        put(4'd4, 12'hA07);
        wait_ready("rstwb");
        req_valid = 1'b1; req_addr = 4'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_wr_en && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("rstwb in WB", n, 2);
        rst_n = 1'b0;
        #1;
        check("rstwb wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rstwb counters", {16'd0, corr_cnt, uncorr_cnt}, 32'd0);
        check("rstwb outs", {20'd0, mem_addr, req_ready, rsp_valid, scrub_busy, rsp_corr, rsp_data},
              32'd0);
        check("rstwb wdata", {20'd0, mem_wdata}, 32'd0);
        @(posedge clk); #1;
        check("rstwb store kept", {20'd0, store[4]}, {20'd0, 12'hA07});
        rst_n = 1'b1;
        do_read("post reset", 4'd3, 8'hA5, 1'b0, 1'b0, 3, 0, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
